eth_frame_filter: RTL and testbench

- Sits between the Ethernet byte receiver and the write side of the RX-to-UART async FIFO, in the PHY_RX_CLK domain.
- Consumes the raw receive byte stream: preamble, SFD, header, payload and FCS.
- Accepts only frames addressed to this node (or broadcast) with the selected EtherType, and forwards payload bytes only, with the FCS stripped.
- Checks CRC-32 per frame and keeps saturating statistics, so only useful data reaches the UART.

---
 rtl/eth_frame_filter.sv | 174 +++++++++++++++++
 tb/tb_eth_frame_filter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_filter.sv
// Receive-side Ethernet frame filter: strips preamble/header/FCS, forwards accepted
// payload bytes to the FIFO write port, checks CRC-32 and keeps saturating stats.
module eth_frame_filter #(
   parameter logic [47:0] LOCAL_MAC    = 48'h00_0A_35_00_01_02,
   parameter bit          ACCEPT_BCAST = 1'b1,
   parameter logic [15:0] ETHERTYPE    = 16'h0000,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             rx_dv,
   input  logic             fifo_full,
   output logic [7:0]       out_data,
   output logic             out_valid,
   output logic             frame_done,
   output logic             crc_ok,
   output logic [CNT_W-1:0] frame_count,
   output logic [CNT_W-1:0] drop_count
);

   typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP} state_t;

   localparam logic [5:0][7:0] MAC_B   = LOCAL_MAC;
   localparam logic [31:0]     RESIDUE = 32'hDEBB20E3;

   state_t           state_q, state_d;
   logic             rx_dv_q;
   logic [31:0]      crc_q, crc_d;
   logic [3:0]       hcnt_q, hcnt_d;
   logic             mac_loc_q, mac_loc_d, mac_bc_q, mac_bc_d;
   logic [7:0]       et_hi_q, et_hi_d;
   logic [3:0][7:0]  dl_q, dl_d;
   logic [3:0]       dl_vld_q, dl_vld_d;
   logic [2:0]       pcnt_q, pcnt_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             frame_done_q, frame_done_d;
   logic             crc_ok_q, crc_ok_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
   logic             dv_rise, dv_fall;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign dv_rise = !rx_dv_q && rx_dv;
   assign dv_fall = rx_dv_q && !rx_dv;

   always_comb begin
      state_d      = state_q;
      crc_d        = crc_q;
      hcnt_d       = hcnt_q;
      mac_loc_d    = mac_loc_q;
      mac_bc_d     = mac_bc_q;
      et_hi_d      = et_hi_q;
      dl_d         = dl_q;
      dl_vld_d     = dl_vld_q;
      pcnt_d       = pcnt_q;
      out_data_d   = out_data_q;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      crc_ok_d     = crc_ok_q;
      frame_cnt_d  = frame_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      case (state_q)
         IDLE: if (dv_rise) state_d = PREAMBLE;
         PREAMBLE: if (rx_valid) begin
            if (rx_data == 8'hD5) begin
               state_d   = HEADER;
               hcnt_d    = 4'd0;
               crc_d     = 32'hFFFFFFFF;
               mac_loc_d = 1'b1;
               mac_bc_d  = 1'b1;
            end else if (rx_data != 8'h55) begin
               state_d = DROP;
            end
         end
         HEADER: if (rx_valid) begin
            crc_d  = crc_byte(crc_q, rx_data);
            hcnt_d = hcnt_q + 4'd1;
            if (hcnt_q < 4'd6) begin
               mac_loc_d = mac_loc_q && (rx_data == MAC_B[3'd5 - hcnt_q[2:0]]);
               mac_bc_d  = mac_bc_q && (rx_data == 8'hFF);
            end
            if (hcnt_q == 4'd5 && !(mac_loc_d || (ACCEPT_BCAST && mac_bc_d))) state_d = DROP;
            if (hcnt_q == 4'd12) et_hi_d = rx_data;
            if (hcnt_q == 4'd13) begin
               state_d  = (ETHERTYPE != 16'h0 && {et_hi_q, rx_data} != ETHERTYPE) ? DROP : PAYLOAD;
               pcnt_d   = 3'd0;
               dl_vld_d = 4'b0;
            end
         end
         PAYLOAD: if (rx_valid) begin
            crc_d    = crc_byte(crc_q, rx_data);
            if (pcnt_q != 3'd4) pcnt_d = pcnt_q + 3'd1;
            // Four-byte delay line: whatever is still inside at frame end is the FCS.
            dl_d     = {dl_q[2:0], rx_data};
            dl_vld_d = {dl_vld_q[2:0], 1'b1};
            if (dl_vld_q[3]) begin
               if (fifo_full) begin
                  if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
               end else begin
                  out_valid_d = 1'b1;
                  out_data_d  = dl_q[3];
               end
            end
         end
         DROP: ;
         default: state_d = IDLE;
      endcase
      // A byte arriving with the falling edge has already been folded in above.
      if (dv_fall && state_q != IDLE) begin
         state_d  = IDLE;
         dl_vld_d = 4'b0;
         if (state_q == PAYLOAD) begin
            frame_done_d = 1'b1;
            crc_ok_d     = (pcnt_d >= 3'd4) && (crc_d == RESIDUE);
            if (crc_ok_d && frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         // Held high so a frame already in progress at reset release is not mistaken for a new one.
         rx_dv_q      <= 1'b1;
         crc_q        <= 32'hFFFFFFFF;
         hcnt_q       <= 4'd0;
         mac_loc_q    <= 1'b0;
         mac_bc_q     <= 1'b0;
         et_hi_q      <= 8'h0;
         dl_q         <= '0;
         dl_vld_q     <= 4'b0;
         pcnt_q       <= 3'd0;
         out_data_q   <= 8'h0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         crc_ok_q     <= 1'b0;
         frame_cnt_q  <= '0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         rx_dv_q      <= rx_dv;
         crc_q        <= crc_d;
         hcnt_q       <= hcnt_d;
         mac_loc_q    <= mac_loc_d;
         mac_bc_q     <= mac_bc_d;
         et_hi_q      <= et_hi_d;
         dl_q         <= dl_d;
         dl_vld_q     <= dl_vld_d;
         pcnt_q       <= pcnt_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         crc_ok_q     <= crc_ok_d;
         frame_cnt_q  <= frame_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign frame_done  = frame_done_q;
   assign crc_ok      = crc_ok_q;
   assign frame_count = frame_cnt_q;
   assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_eth_frame_filter.sv
// Bench for eth_frame_filter: two instances (EtherType any / 0x0806) fed the same byte
// stream; a frame-level model predicts payload bytes, verdicts and counters.
module tb_eth_frame_filter;
   localparam logic [47:0] LMAC  = 48'h00_0A_35_00_01_02;
   localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] rx_data = 8'h0;
   logic rx_valid = 1'b0, rx_dv = 1'b0, fifo_full = 1'b0;
   wire [1:0] ov, fd, ck;
   wire [1:0][7:0] od;
   wire [1:0][15:0] fc, dc;

   always #5 clk = ~clk;

   eth_frame_filter dut0 (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_dv(rx_dv),
      .fifo_full(fifo_full), .out_data(od[0]), .out_valid(ov[0]), .frame_done(fd[0]),
      .crc_ok(ck[0]), .frame_count(fc[0]), .drop_count(dc[0]));

   eth_frame_filter #(.ETHERTYPE(16'h0806)) dut1 (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_dv(rx_dv),
      .fifo_full(fifo_full), .out_data(od[1]), .out_valid(ov[1]), .frame_done(fd[1]),
      .crc_ok(ck[1]), .frame_count(fc[1]), .drop_count(dc[1]));

   int checks = 0, errors = 0;
   logic [7:0]  fb[$];
   logic [7:0]  eq0[$], eq1[$];
   logic [16:0] fq0[$], fq1[$];
   int mcnt[2], mdrop[2], npulse[2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Bit-serial reflected CRC-32, one input bit at a time.
   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      for (int i = 0; i < 8; i++) c = (c >> 1) ^ ((c[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
      return c;
   endfunction

   task automatic build(input logic [47:0] dst, input logic [15:0] et, input int np);
      logic [31:0] c;
      fb.delete();
      repeat (7) fb.push_back(8'h55);
      fb.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) fb.push_back(dst[8*i +: 8]);
      for (int i = 0; i < 6; i++) fb.push_back(8'(i * 17));
      fb.push_back(et[15:8]);
      fb.push_back(et[7:0]);
      for (int i = 0; i < np; i++) fb.push_back(8'(i));
      c = 32'hFFFFFFFF;
      for (int i = 8; i < fb.size(); i++) c = crc_upd(c, fb[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
   endtask

   // Frame-level prediction: accept rules, FCS comparison, bytes lost to fifo_full.
   task automatic expect_frame(input int d, input int flo, input int fhi);
      logic [15:0] et;
      logic [47:0] dst;
      logic [31:0] c, fcs;
      bit acc, good;
      int n, sz;
      et = (d == 0) ? 16'h0000 : 16'h0806;
      sz = fb.size();
      if (sz < 22) return;
      n = sz - 22;
      acc = (fb[7] == 8'hD5);
      for (int i = 0; i < 7; i++) acc = acc && (fb[i] == 8'h55);
      dst = {fb[8], fb[9], fb[10], fb[11], fb[12], fb[13]};
      acc = acc && (dst == LMAC || dst == BCAST) && (et == 16'h0 || {fb[20], fb[21]} == et);
      if (!acc) return;
      good = 1'b0;
      if (n >= 4) begin
         c = 32'hFFFFFFFF;
         for (int i = 8; i < sz - 4; i++) c = crc_upd(c, fb[i]);
         fcs = {fb[sz-1], fb[sz-2], fb[sz-3], fb[sz-4]};
         good = (~c == fcs);
      end
      for (int k = 0; k < n - 4; k++) begin
         if (k >= flo && k <= fhi) mdrop[d]++;
         else if (d == 0) eq0.push_back(fb[22+k]);
         else eq1.push_back(fb[22+k]);
      end
      if (good) mcnt[d]++;
      if (d == 0) fq0.push_back({good, 16'(mcnt[d])});
      else fq1.push_back({good, 16'(mcnt[d])});
   endtask

   task automatic pop_b(input int d, output bit ok, output logic [7:0] v);
      ok = 1'b0; v = 8'h0;
      if (d == 0 && eq0.size() > 0) begin ok = 1'b1; v = eq0.pop_front(); end
      if (d == 1 && eq1.size() > 0) begin ok = 1'b1; v = eq1.pop_front(); end
   endtask

   task automatic pop_f(input int d, output bit ok, output logic [16:0] v);
      ok = 1'b0; v = 17'h0;
      if (d == 0 && fq0.size() > 0) begin ok = 1'b1; v = fq0.pop_front(); end
      if (d == 1 && fq1.size() > 0) begin ok = 1'b1; v = fq1.pop_front(); end
   endtask

   always @(negedge clk) begin : cmp
      bit ok;
      logic [7:0] v;
      logic [16:0] f;
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            if (ov[d]) begin
               npulse[d]++;
               pop_b(d, ok, v);
               chk($sformatf("dut%0d out_valid wanted", d), 32'(ok), 32'd1);
               if (ok) chk($sformatf("dut%0d out_data", d), 32'(od[d]), 32'(v));
            end
            if (fd[d]) begin
               pop_f(d, ok, f);
               chk($sformatf("dut%0d frame_done wanted", d), 32'(ok), 32'd1);
               if (ok) begin
                  chk($sformatf("dut%0d crc_ok", d), 32'(ck[d]), 32'(f[16]));
                  chk($sformatf("dut%0d frame_count", d), 32'(fc[d]), 32'(f[15:0]));
               end
            end
         end
      end
   end

   task automatic chk_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s dut%0d out_valid", tag, d), 32'(ov[d]), 32'd0);
         chk($sformatf("%s dut%0d frame_done", tag, d), 32'(fd[d]), 32'd0);
         chk($sformatf("%s dut%0d crc_ok", tag, d), 32'(ck[d]), 32'd0);
         chk($sformatf("%s dut%0d frame_count", tag, d), 32'(fc[d]), 32'd0);
         chk($sformatf("%s dut%0d drop_count", tag, d), 32'(dc[d]), 32'd0);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      @(negedge clk);
      #1 rx_valid = 1'b0;
      rst = 1'b1;
      eq0.delete(); eq1.delete(); fq0.delete(); fq1.delete();
      for (int d = 0; d < 2; d++) begin mcnt[d] = 0; mdrop[d] = 0; end
      #1 chk_zero("mid-frame reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send(input int flo, input int fhi, input int rst_at, input bit gaps);
      npulse[0] = 0; npulse[1] = 0;
      expect_frame(0, flo, fhi);
      expect_frame(1, flo, fhi);
      @(posedge clk);
      #1 rx_dv = 1'b1;
      for (int i = 0; i < fb.size(); i++) begin
         if (i == 22 + rst_at) do_reset();
         if (gaps && (i % 3 == 2)) begin @(posedge clk); #1 rx_valid = 1'b0; end
         @(posedge clk);
         #1 rx_data = fb[i];
         rx_valid  = 1'b1;
         fifo_full = (i - 26 >= flo) && (i - 26 <= fhi);
      end
      @(posedge clk);
      #1 rx_valid = 1'b0; rx_dv = 1'b0; fifo_full = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("dut0 bytes still owed", eq0.size(), 0);
      chk("dut1 bytes still owed", eq1.size(), 0);
      chk("dut0 frame_done still owed", fq0.size(), 0);
      chk("dut1 frame_done still owed", fq1.size(), 0);
      chk("dut0 drop_count", 32'(dc[0]), 32'(mdrop[0]));
      chk("dut1 drop_count", 32'(dc[1]), 32'(mdrop[1]));
   endtask

   initial begin : stim
      logic [31:0] c;
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      rst = 1'b0;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 9; i++) c = crc_upd(c, 8'(8'h31 + i));
      chk("model crc32 check value", ~c, 32'hCBF43926);

      build(BCAST, 16'h0800, 46);
      send(1000, -1, -1000, 1'b0);
      chk("good bcast pulses", npulse[0], 46);
      chk("good bcast crc_ok", 32'(ck[0]), 32'd1);
      chk("good bcast frame_count", 32'(fc[0]), 32'd1);
      chk("good bcast drop_count", 32'(dc[0]), 32'd0);
      chk("type filter pulses", npulse[1], 0);

      build(BCAST, 16'h0800, 46);
      fb[32] = 8'hFF;
      send(1000, -1, -1000, 1'b0);
      chk("bad crc pulses", npulse[0], 46);
      chk("bad crc crc_ok", 32'(ck[0]), 32'd0);
      chk("bad crc frame_count", 32'(fc[0]), 32'd1);

      build(48'h02_00_00_00_00_99, 16'h0800, 46);
      send(1000, -1, -1000, 1'b0);
      chk("foreign dest pulses", npulse[0], 0);
      build(LMAC, 16'h0800, 20);
      send(1000, -1, -1000, 1'b0);
      chk("local dest pulses", npulse[0], 20);
      chk("local dest frame_count", 32'(fc[0]), 32'd2);

      build(LMAC, 16'h0806, 30);
      send(1000, -1, -1000, 1'b1);
      chk("arp type pulses", npulse[1], 30);
      chk("arp type frame_count", 32'(fc[1]), 32'd1);
      chk("any type frame_count", 32'(fc[0]), 32'd3);

      build(BCAST, 16'h0800, 46);
      send(5, 9, -1000, 1'b0);
      chk("fifo_full pulses", npulse[0], 41);
      chk("fifo_full drop_count", 32'(dc[0]), 32'd5);
      chk("fifo_full crc_ok", 32'(ck[0]), 32'd1);

      build(BCAST, 16'h0800, 0);
      void'(fb.pop_back());
      void'(fb.pop_back());
      send(1000, -1, -1000, 1'b0);
      chk("short frame crc_ok", 32'(ck[0]), 32'd0);
      chk("short frame frame_count", 32'(fc[0]), 32'd4);

      build(BCAST, 16'h0800, 10);
      fb[3] = 8'h12;
      send(1000, -1, -1000, 1'b0);
      chk("bad preamble pulses", npulse[0], 0);

      build(BCAST, 16'h0800, 46);
      send(1000, -1, 20, 1'b0);
      chk("after reset frame_count", 32'(fc[0]), 32'd0);
      build(LMAC, 16'h0800, 46);
      send(1000, -1, -1000, 1'b0);
      chk("post-reset pulses", npulse[0], 46);
      chk("post-reset frame_count", 32'(fc[0]), 32'd1);
      chk("post-reset crc_ok", 32'(ck[0]), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
